// File: rtl/ddr3_init_pkg.sv
// ddr3_init_pkg
// Shared definitions for the DDR3 power-up initialisation sequencer:
//   - state_t      : sequencer state encoding
//   - cmd_t        : {ras, cas, we} command-line encoding, plus the
//                    NOP / DESELECT / MRS / ZQCL constants
//   - MR_ORDER     : order in which mode registers are programmed (2,3,1,0)
//   - helper functions for the MR order lookup and timer sizing
package ddr3_init_pkg;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        RST_HOLD = 4'd1,
        CKE_WAIT = 4'd2,
        XPR_WAIT = 4'd3,
        MR_ISSUE = 4'd4,
        MR_WAIT  = 4'd5,
        ZQ_ISSUE = 4'd6,
        ZQ_WAIT  = 4'd7,
        DONE     = 4'd8
    } state_t;

    typedef struct packed {
        logic ras;
        logic cas;
        logic we;
    } cmd_t;

    // DESELECT and NOP share the command-line pattern; they differ only in
    // whether chip selects are asserted.
    localparam cmd_t CMD_NOP      = 3'b111;
    localparam cmd_t CMD_DESELECT = 3'b111;
    localparam cmd_t CMD_MRS      = 3'b000;
    localparam cmd_t CMD_ZQCL     = 3'b110;

    // ZQCL is distinguished from ZQCS by a[10]=1.
    localparam logic [13:0] ZQCL_ADDR = 14'h0400;

    // Mode-register issue order, slot 0 in the low bits: MR2, MR3, MR1, MR0.
    localparam logic [11:0] MR_ORDER = {3'd0, 3'd1, 3'd3, 3'd2};

    // Bank address (mode register index) programmed in issue slot idx.
    function automatic logic [2:0] mr_order_ba(input logic [1:0] idx);
        logic [2:0] ba;
        case (idx)
            2'd0:    ba = MR_ORDER[2:0];
            2'd1:    ba = MR_ORDER[5:3];
            2'd2:    ba = MR_ORDER[8:6];
            2'd3:    ba = MR_ORDER[11:9];
            default: ba = 3'd0;
        endcase
        return ba;
    endfunction

    function automatic int max2(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

    // Timer is loaded with (T - 1), so it must hold values up to max_t - 1.
    function automatic int timer_width(input int max_t);
        return (max_t < 2) ? 1 : $clog2(max_t);
    endfunction

endpackage

// File: rtl/ddr3_wait_timer.sv
// ddr3_wait_timer
// Loadable down-counter used for every timed wait of the sequencer.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous active-high reset, clears the count
//   load  : load value into the counter this cycle
//   value : count to load (a wait of N cycles is loaded as N-1)
//   done  : high while the count is zero
module ddr3_wait_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         done
);

    logic [W-1:0] count_r;

    // Count register: load has priority, otherwise decrement and hold at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= {W{1'b0}};
        end else if (load) begin
            count_r <= value;
        end else if (count_r != {W{1'b0}}) begin
            count_r <= count_r - W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign done = (count_r == {W{1'b0}});

endmodule

// File: rtl/ddr3_init_seq.sv
// ddr3_init_seq
// DDR3 power-up initialisation sequencer. A rising edge on initddr (from
// IDLE or DONE) runs: reset hold, CKE wait, tXPR wait, then per rank the
// MRS MR2/MR3/MR1/MR0 and ZQCL commands with the required spacing.
// Ports:
//   clk, reset          : clock and synchronous active-high reset
//   initddr             : level request, rising edge starts a sequence
//   ready / busy        : sequence complete / sequence running
//   resetbar, cke       : DRAM reset and clock enable
//   csbar[RANKS-1:0]    : per-rank chip selects, active low
//   rasbar/casbar/webar : command lines
//   ba, a               : bank address / address
//   odt                 : on-die termination, always 0
// All outputs are registered and reflect the state held during the
// previous cycle, so every phase appears on the pins one cycle after the
// state register enters it.
module ddr3_init_seq
    import ddr3_init_pkg::*;
#(
    parameter int          RANKS    = 1,
    parameter int          T_RESET  = 320000,
    parameter int          T_CKE    = 800000,
    parameter int          T_XPR    = 180,
    parameter int          T_MRD    = 4,
    parameter int          T_MOD    = 12,
    parameter int          T_ZQINIT = 512,
    parameter logic [13:0] MR0      = 14'h0,
    parameter logic [13:0] MR1      = 14'h0,
    parameter logic [13:0] MR2      = 14'h0,
    parameter logic [13:0] MR3      = 14'h0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             initddr,
    output logic             ready,
    output logic             busy,
    output logic             resetbar,
    output logic             cke,
    output logic [RANKS-1:0] csbar,
    output logic             rasbar,
    output logic             casbar,
    output logic             webar,
    output logic [2:0]       ba,
    output logic [13:0]      a,
    output logic             odt
);

    localparam int T_MAX = max2(max2(max2(T_RESET, T_CKE), max2(T_XPR, T_MRD)),
                                max2(T_MOD, T_ZQINIT));
    localparam int TW    = timer_width(T_MAX);

    // Every wait of N cycles is loaded as N-1 on entry to the state.
    localparam logic [TW-1:0] LD_RESET = TW'(T_RESET - 1);
    localparam logic [TW-1:0] LD_CKE   = TW'(T_CKE - 1);
    localparam logic [TW-1:0] LD_XPR   = TW'(T_XPR - 1);
    localparam logic [TW-1:0] LD_MRD   = TW'(T_MRD - 1);
    localparam logic [TW-1:0] LD_MOD   = TW'(T_MOD - 1);
    localparam logic [TW-1:0] LD_ZQ    = TW'(T_ZQINIT - 1);

    localparam logic [1:0]       LAST_RANK = 2'(RANKS - 1);
    localparam logic [1:0]       LAST_MR   = 2'd3;
    localparam logic [RANKS-1:0] RANK0_SEL = RANKS'(1);

    if (RANKS < 1 || RANKS > 4 || T_RESET < 1 || T_CKE < 1 || T_XPR < 1 ||
        T_MRD < 1 || T_MOD < 1 || T_ZQINIT < 1) begin : g_param_check
        $error("ddr3_init_seq: RANKS must be 1..4 and every T_* at least 1");
    end

    state_t           state_r;
    state_t           state_s;
    logic [1:0]       rank_r;
    logic [1:0]       rank_s;
    logic [1:0]       mr_idx_r;
    logic [1:0]       mr_idx_s;
    logic             initddr_r;
    logic             start_s;
    logic             load_s;
    logic [TW-1:0]    load_val_s;
    logic             wait_done_s;

    logic             ready_s;
    logic             busy_s;
    logic             resetbar_s;
    logic             cke_s;
    logic [RANKS-1:0] csbar_s;
    cmd_t             cmd_s;
    logic [2:0]       ba_s;
    logic [13:0]      a_s;

    function automatic logic [13:0] mr_value(input logic [2:0] idx);
        logic [13:0] v;
        case (idx)
            3'd0:    v = MR0;
            3'd1:    v = MR1;
            3'd2:    v = MR2;
            3'd3:    v = MR3;
            default: v = 14'h0;
        endcase
        return v;
    endfunction

    ddr3_wait_timer #(
        .W(TW)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (load_s),
        .value (load_val_s),
        .done  (wait_done_s)
    );

    assign start_s = initddr & ~initddr_r;

    // Next-state logic; each transition into a timed state loads its wait.
    always_comb begin
        state_s    = state_r;
        rank_s     = rank_r;
        mr_idx_s   = mr_idx_r;
        load_s     = 1'b0;
        load_val_s = {TW{1'b0}};
        case (state_r)
            IDLE, DONE: begin
                if (start_s) begin
                    state_s    = RST_HOLD;
                    rank_s     = 2'd0;
                    mr_idx_s   = 2'd0;
                    load_s     = 1'b1;
                    load_val_s = LD_RESET;
                end else begin
                    state_s = state_r;
                end
            end
            RST_HOLD: begin
                if (wait_done_s) begin
                    state_s    = CKE_WAIT;
                    load_s     = 1'b1;
                    load_val_s = LD_CKE;
                end else begin
                    state_s = RST_HOLD;
                end
            end
            CKE_WAIT: begin
                if (wait_done_s) begin
                    state_s    = XPR_WAIT;
                    load_s     = 1'b1;
                    load_val_s = LD_XPR;
                end else begin
                    state_s = CKE_WAIT;
                end
            end
            XPR_WAIT: begin
                if (wait_done_s) begin
                    state_s    = MR_ISSUE;
                    mr_idx_s   = 2'd0;
                    load_s     = 1'b1;
                    load_val_s = LD_MRD;
                end else begin
                    state_s = XPR_WAIT;
                end
            end
            // The command cycle counts toward the spacing, so with a spacing
            // of one the issue state chains straight to the next command.
            MR_ISSUE, MR_WAIT: begin
                if (wait_done_s) begin
                    if (mr_idx_r == LAST_MR) begin
                        state_s    = ZQ_ISSUE;
                        load_s     = 1'b1;
                        load_val_s = LD_ZQ;
                    end else begin
                        state_s    = MR_ISSUE;
                        mr_idx_s   = mr_idx_r + 2'd1;
                        load_s     = 1'b1;
                        load_val_s = (mr_idx_s == LAST_MR) ? LD_MOD : LD_MRD;
                    end
                end else begin
                    state_s = MR_WAIT;
                end
            end
            ZQ_ISSUE, ZQ_WAIT: begin
                if (wait_done_s) begin
                    if (rank_r == LAST_RANK) begin
                        state_s = DONE;
                    end else begin
                        state_s    = MR_ISSUE;
                        rank_s     = rank_r + 2'd1;
                        mr_idx_s   = 2'd0;
                        load_s     = 1'b1;
                        load_val_s = LD_MRD;
                    end
                end else begin
                    state_s = ZQ_WAIT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, rank/MR counters and the registered copy of initddr.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            rank_r    <= 2'd0;
            mr_idx_r  <= 2'd0;
            initddr_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            rank_r    <= rank_s;
            mr_idx_r  <= mr_idx_s;
            initddr_r <= initddr;
        end
    end

    // Pin values for the current state; IDLE matches the reset values.
    always_comb begin
        ready_s    = 1'b0;
        busy_s     = 1'b0;
        resetbar_s = 1'b0;
        cke_s      = 1'b0;
        csbar_s    = {RANKS{1'b1}};
        cmd_s      = CMD_DESELECT;
        ba_s       = 3'd0;
        a_s        = 14'h0;
        case (state_r)
            IDLE: begin
                busy_s = 1'b0;
            end
            RST_HOLD: begin
                busy_s = 1'b1;
            end
            CKE_WAIT: begin
                busy_s     = 1'b1;
                resetbar_s = 1'b1;
            end
            XPR_WAIT, MR_WAIT, ZQ_WAIT: begin
                busy_s     = 1'b1;
                resetbar_s = 1'b1;
                cke_s      = 1'b1;
                csbar_s    = {RANKS{1'b0}};
                cmd_s      = CMD_NOP;
            end
            MR_ISSUE: begin
                busy_s     = 1'b1;
                resetbar_s = 1'b1;
                cke_s      = 1'b1;
                csbar_s    = ~(RANK0_SEL << rank_r);
                cmd_s      = CMD_MRS;
                ba_s       = mr_order_ba(mr_idx_r);
                a_s        = mr_value(ba_s);
            end
            ZQ_ISSUE: begin
                busy_s     = 1'b1;
                resetbar_s = 1'b1;
                cke_s      = 1'b1;
                csbar_s    = ~(RANK0_SEL << rank_r);
                cmd_s      = CMD_ZQCL;
                a_s        = ZQCL_ADDR;
            end
            DONE: begin
                ready_s    = 1'b1;
                resetbar_s = 1'b1;
                cke_s      = 1'b1;
                csbar_s    = {RANKS{1'b0}};
                cmd_s      = CMD_NOP;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            ready    <= 1'b0;
            busy     <= 1'b0;
            resetbar <= 1'b0;
            cke      <= 1'b0;
            csbar    <= {RANKS{1'b1}};
            rasbar   <= 1'b1;
            casbar   <= 1'b1;
            webar    <= 1'b1;
            ba       <= 3'd0;
            a        <= 14'h0;
            odt      <= 1'b0;
        end else begin
            ready    <= ready_s;
            busy     <= busy_s;
            resetbar <= resetbar_s;
            cke      <= cke_s;
            csbar    <= csbar_s;
            rasbar   <= cmd_s.ras;
            casbar   <= cmd_s.cas;
            webar    <= cmd_s.we;
            ba       <= ba_s;
            a        <= a_s;
            odt      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ddr3_init_seq.sv
// Testbench for ddr3_init_seq: a two-rank instance with short timings and a
// single-rank instance with every timing at 1. A time-based model predicts
// every output on every cycle; directed checks pin latencies and the
// command stream with hand-computed literals.
module tb_ddr3_init_seq;

    localparam logic [13:0] MRV0 = 14'h1520;
    localparam logic [13:0] MRV1 = 14'h0044;
    localparam logic [13:0] MRV2 = 14'h0010;
    localparam logic [13:0] MRV3 = 14'h0004;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    // Sequence length (model time units) before DONE: 8+10+5+2*(12+12+16)
    localparam int TOT1 = 103;
    // 1+1+1+(3+1+1)
    localparam int TOT2 = 8;

    typedef struct packed {
        logic        ready;
        logic        busy;
        logic        resetbar;
        logic        cke;
        logic [1:0]  csbar;
        logic        ras;
        logic        cas;
        logic        we;
        logic [2:0]  ba;
        logic [13:0] a;
        logic        odt;
    } out_t;

    typedef struct {
        int          cyc;
        logic [1:0]  cs;
        logic [2:0]  ba;
        logic [13:0] a;
        logic [2:0]  rcw;
    } rec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, initddr, reset2, initddr2;

    logic        d1_ready, d1_busy, d1_resetbar, d1_cke, d1_ras, d1_cas, d1_we, d1_odt;
    logic [1:0]  d1_csbar;
    logic [2:0]  d1_ba;
    logic [13:0] d1_a;
    logic        d2_ready, d2_busy, d2_resetbar, d2_cke, d2_ras, d2_cas, d2_we, d2_odt;
    logic [0:0]  d2_csbar;
    logic [2:0]  d2_ba;
    logic [13:0] d2_a;

    ddr3_init_seq #(
        .RANKS(2), .T_RESET(8), .T_CKE(10), .T_XPR(5), .T_MRD(4), .T_MOD(12),
        .T_ZQINIT(16), .MR0(MRV0), .MR1(MRV1), .MR2(MRV2), .MR3(MRV3)
    ) dut (
        .clk(clk), .reset(reset), .initddr(initddr), .ready(d1_ready), .busy(d1_busy),
        .resetbar(d1_resetbar), .cke(d1_cke), .csbar(d1_csbar), .rasbar(d1_ras),
        .casbar(d1_cas), .webar(d1_we), .ba(d1_ba), .a(d1_a), .odt(d1_odt)
    );

    ddr3_init_seq #(
        .RANKS(1), .T_RESET(1), .T_CKE(1), .T_XPR(1), .T_MRD(1), .T_MOD(1),
        .T_ZQINIT(1)
    ) dut_min (
        .clk(clk), .reset(reset2), .initddr(initddr2), .ready(d2_ready), .busy(d2_busy),
        .resetbar(d2_resetbar), .cke(d2_cke), .csbar(d2_csbar), .rasbar(d2_ras),
        .casbar(d2_cas), .webar(d2_we), .ba(d2_ba), .a(d2_a), .odt(d2_odt)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    bit cmp_en = 1'b0;
    rec_t log1[$];
    rec_t log2[$];

    // Expected pins while the sequence sits at time t (cycles since start).
    function automatic out_t model_out(input int mode, input int t, input int ranks,
                                       input int tr, input int tc, input int tx,
                                       input int tm, input int tmod, input int tzq,
                                       input logic [13:0] m0, input logic [13:0] m1,
                                       input logic [13:0] m2, input logic [13:0] m3);
        out_t o;
        logic [1:0] nopcs;
        logic [1:0] one;
        int base, p, u, rk, off, k;
        o = '0;
        o.csbar = 2'b11;
        o.ras = 1'b1; o.cas = 1'b1; o.we = 1'b1;
        one = 2'b01;
        nopcs = (ranks == 1) ? 2'b10 : 2'b00;
        if (mode == M_DONE) begin
            o.ready = 1'b1; o.resetbar = 1'b1; o.cke = 1'b1; o.csbar = nopcs;
        end else if (mode == M_RUN) begin
            o.busy = 1'b1;
            if (t >= tr) o.resetbar = 1'b1;
            if (t >= tr + tc) begin
                o.cke = 1'b1;
                o.csbar = nopcs;
            end
            base = tr + tc + tx;
            if (t >= base) begin
                p = 3 * tm + tmod + tzq;
                u = t - base;
                rk = u / p;
                off = u % p;
                k = -1;
                if (off == 0) k = 0;
                else if (off == tm) k = 1;
                else if (off == 2 * tm) k = 2;
                else if (off == 3 * tm) k = 3;
                if (k >= 0) begin
                    o.csbar = ~(one << rk);
                    o.ras = 1'b0; o.cas = 1'b0; o.we = 1'b0;
                    case (k)
                        0: begin o.ba = 3'd2; o.a = m2; end
                        1: begin o.ba = 3'd3; o.a = m3; end
                        2: begin o.ba = 3'd1; o.a = m1; end
                        default: begin o.ba = 3'd0; o.a = m0; end
                    endcase
                end else if (off == 3 * tm + tmod) begin
                    o.csbar = ~(one << rk);
                    o.we = 1'b0;
                    o.a = 14'h0400;
                end
            end
        end
        return o;
    endfunction

    int   m1_mode = M_IDLE, m1_t = 0;
    logic m1_q = 1'b0;
    out_t exp1;
    int   m2_mode = M_IDLE, m2_t = 0;
    logic m2_q = 1'b0;
    out_t exp2;

    always @(posedge clk) cyc <= cyc + 1;

    // Model of the two-rank instance: pins this edge show the previous time.
    always @(posedge clk) begin
        exp1 = model_out(m1_mode, m1_t, 2, 8, 10, 5, 4, 12, 16, MRV0, MRV1, MRV2, MRV3);
        if (reset) begin
            m1_mode = M_IDLE; m1_t = 0; m1_q = 1'b0;
            exp1 = model_out(M_IDLE, 0, 2, 8, 10, 5, 4, 12, 16, MRV0, MRV1, MRV2, MRV3);
        end else begin
            if (m1_mode != M_RUN && initddr && !m1_q) begin
                m1_mode = M_RUN; m1_t = 0;
            end else if (m1_mode == M_RUN) begin
                m1_t++;
                if (m1_t == TOT1) m1_mode = M_DONE;
            end
            m1_q = initddr;
        end
    end

    // Model of the single-rank minimum-timing instance.
    always @(posedge clk) begin
        exp2 = model_out(m2_mode, m2_t, 1, 1, 1, 1, 1, 1, 1, 14'h0, 14'h0, 14'h0, 14'h0);
        if (reset2) begin
            m2_mode = M_IDLE; m2_t = 0; m2_q = 1'b0;
            exp2 = model_out(M_IDLE, 0, 1, 1, 1, 1, 1, 1, 1, 14'h0, 14'h0, 14'h0, 14'h0);
        end else begin
            if (m2_mode != M_RUN && initddr2 && !m2_q) begin
                m2_mode = M_RUN; m2_t = 0;
            end else if (m2_mode == M_RUN) begin
                m2_t++;
                if (m2_t == TOT2) m2_mode = M_DONE;
            end
            m2_q = initddr2;
        end
    end

    // Per-cycle compare against the models plus command logging.
    always @(negedge clk) begin
        out_t act1, act2;
        rec_t r;
        if (cmp_en) begin
            act1 = {d1_ready, d1_busy, d1_resetbar, d1_cke, d1_csbar, d1_ras, d1_cas,
                    d1_we, d1_ba, d1_a, d1_odt};
            act2 = {d2_ready, d2_busy, d2_resetbar, d2_cke, 1'b1, d2_csbar, d2_ras,
                    d2_cas, d2_we, d2_ba, d2_a, d2_odt};
            tests++;
            if (act1 !== exp1) begin
                fails++;
                $display("FAIL model_rank2 cycle %0d: got %h expected %h", cyc, act1, exp1);
            end
            tests++;
            if (act2 !== exp2) begin
                fails++;
                $display("FAIL model_rank1 cycle %0d: got %h expected %h", cyc, act2, exp2);
            end
            if (d1_csbar != 2'b11 && {d1_ras, d1_cas, d1_we} != 3'b111) begin
                r.cyc = cyc; r.cs = d1_csbar; r.ba = d1_ba; r.a = d1_a;
                r.rcw = {d1_ras, d1_cas, d1_we};
                log1.push_back(r);
            end
            if (d2_csbar == 1'b0 && {d2_ras, d2_cas, d2_we} != 3'b111) begin
                r.cyc = cyc; r.cs = {1'b1, d2_csbar}; r.ba = d2_ba; r.a = d2_a;
                r.rcw = {d2_ras, d2_cas, d2_we};
                log2.push_back(r);
            end
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Wait (bounded) for ready to be high after the start edge and check latency.
    task automatic wait_ready_rise(input bit which, input int st, input int exp,
                                   input string nm, output int rbl);
        bit seen;
        int lat;
        seen = 1'b0;
        rbl = 0;
        lat = -1;
        for (int n = 0; n < 400 && !seen; n++) begin
            @(negedge clk);
            if (which == 1'b0 && d1_busy && !d1_resetbar) rbl++;
            if (which == 1'b1 && d2_busy && !d2_resetbar) rbl++;
            if (((which == 1'b0) ? d1_ready : d2_ready) && cyc > st) begin
                seen = 1'b1;
                lat = cyc - st;
            end
        end
        check(nm, lat, exp);
    endtask

    int exp_ba  [5] = '{2, 3, 1, 0, 0};
    int exp_rcw [5] = '{0, 0, 0, 0, 6};
    int exp_gap [10] = '{0, 4, 4, 4, 12, 16, 4, 4, 4, 12};
    logic [13:0] exp_a [5];

    initial begin
        int st, rbl;
        exp_a[0] = MRV2; exp_a[1] = MRV3; exp_a[2] = MRV1; exp_a[3] = MRV0;
        exp_a[4] = 14'h0400;
        reset = 1'b1; initddr = 1'b0; reset2 = 1'b1; initddr2 = 1'b0;
        @(posedge clk);
        #1 cmp_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        check("reset_ready", d1_ready, 0);
        check("reset_busy", d1_busy, 0);
        check("reset_resetbar", d1_resetbar, 0);
        check("reset_csbar", d1_csbar, 3);
        check("reset_cmd", {d1_ras, d1_cas, d1_we}, 7);

        // Minimum timing, initddr already high when reset releases.
        initddr2 = 1'b1;
        @(negedge clk);
        reset2 = 1'b0;
        log2.delete();
        st = cyc + 1;
        wait_ready_rise(1'b1, st, 9, "min_ready_latency", rbl);
        check("min_resetbar_low", rbl, 1);
        check("min_cmd_count", log2.size(), 5);
        if (log2.size() == 5) begin
            check("min_first_cmd", log2[0].cyc - st, 4);
            for (int i = 0; i < 5; i++) begin
                check($sformatf("min_cmd%0d_ba", i), log2[i].ba, exp_ba[i]);
                check($sformatf("min_cmd%0d_rcw", i), log2[i].rcw, exp_rcw[i]);
                if (i > 0) check($sformatf("min_cmd%0d_gap", i), log2[i].cyc - log2[i-1].cyc, 1);
            end
        end

        // Full two-rank sequence.
        log1.delete();
        @(posedge clk);
        #1 initddr = 1'b1;
        st = cyc + 1;
        wait_ready_rise(1'b0, st, 104, "seqA_ready_latency", rbl);
        check("seqA_resetbar_low", rbl, 8);
        check("seqA_cmd_count", log1.size(), 10);
        if (log1.size() == 10) begin
            check("seqA_first_cmd", log1[0].cyc - st, 24);
            for (int i = 0; i < 10; i++) begin
                check($sformatf("seqA_cmd%0d_ba", i), log1[i].ba, exp_ba[i % 5]);
                check($sformatf("seqA_cmd%0d_a", i), log1[i].a, exp_a[i % 5]);
                check($sformatf("seqA_cmd%0d_rcw", i), log1[i].rcw, exp_rcw[i % 5]);
                check($sformatf("seqA_cmd%0d_cs", i), log1[i].cs, (i < 5) ? 2 : 1);
                if (i > 0) check($sformatf("seqA_cmd%0d_gap", i),
                                 log1[i].cyc - log1[i-1].cyc, exp_gap[i]);
            end
        end

        // Restart from DONE, with an initddr toggle while busy.
        @(posedge clk);
        #1 initddr = 1'b0;
        repeat (3) @(posedge clk);
        #1 initddr = 1'b1;
        st = cyc + 1;
        while (cyc < st + 1) @(negedge clk);
        check("restart_ready_drop", d1_ready, 0);
        check("restart_busy", d1_busy, 1);
        while (cyc < st + 40) @(negedge clk);
        initddr = 1'b0;
        while (cyc < st + 45) @(negedge clk);
        initddr = 1'b1;
        wait_ready_rise(1'b0, st, 104, "seqB_ready_latency", rbl);

        // Reset pulse mid-sequence, then a fresh full sequence.
        @(negedge clk);
        initddr = 1'b0;
        repeat (2) @(negedge clk);
        initddr = 1'b1;
        st = cyc + 1;
        while (cyc < st + 29) @(negedge clk);
        reset = 1'b1;
        initddr = 1'b0;
        @(negedge clk);
        check("midreset_busy", d1_busy, 0);
        check("midreset_resetbar", d1_resetbar, 0);
        check("midreset_cke", d1_cke, 0);
        check("midreset_csbar", d1_csbar, 3);
        check("midreset_a", d1_a, 0);
        reset = 1'b0;
        @(negedge clk);
        initddr = 1'b1;
        st = cyc + 1;
        wait_ready_rise(1'b0, st, 104, "seqC_ready_latency", rbl);
        check("seqC_resetbar_low", rbl, 8);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ddr3_init_seq.md
DDR3_INIT_SEQ -- requirements
Module: ddr3_init_seq

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- RANKS, 1, number of chip selects initialised (1..4)
- T_RESET, 320000, cycles with resetbar low
- T_CKE, 800000, cycles from resetbar high to cke high
- T_XPR, 180, cycles from cke high to first MRS
- T_MRD, 4, MRS-to-MRS command spacing, cycles
- T_MOD, 12, MR0-to-ZQCL spacing, cycles
- T_ZQINIT, 512, ZQCL-to-next-command spacing, cycles
- MR0..MR3, 14'h0, mode register values driven on a during MRS
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- initddr  in  1  level request; rising edge starts a sequence
- ready  out  1  high when initialisation is complete
- busy  out  1  high while a sequence is running
- resetbar  out  1  DRAM reset
- cke  out  1  clock enable
- csbar  out  RANKS  per-rank chip select, active low
- rasbar, casbar, webar  out  1 each  command lines
- ba  out  3  bank address
- a  out  14  address
- odt  out  1  on-die termination, held 0

Function
REQ-003 States SHALL be IDLE, RST_HOLD, CKE_WAIT, XPR_WAIT, MR_ISSUE, MR_WAIT, ZQ_ISSUE, ZQ_WAIT, DONE.
REQ-004 IDLE -> RST_HOLD on the first cycle initddr is high with its registered copy low; in DONE the same rising edge SHALL restart at RST_HOLD, and ready SHALL drop on the next cycle.
REQ-005 initddr edges during busy SHALL be ignored.
REQ-006 RST_HOLD: resetbar=0, cke=0, csbar all 1, for exactly T_RESET cycles; CKE_WAIT: resetbar=1, cke=0, for T_CKE cycles; XPR_WAIT: cke=1, NOP, for T_XPR cycles.
REQ-007 Per rank r = 0..RANKS-1 in order: MRS MR2, MR3, MR1, MR0, then ZQCL, each a one-cycle command with csbar[r]=0 and other ranks 1.
REQ-008 Command spacing SHALL be T_MRD after MR2/MR3/MR1, T_MOD after MR0, T_ZQINIT after ZQCL; gaps SHALL drive NOP.
REQ-009 MRS encoding: ras/cas/we = 0/0/0, ba = MR index, a = MRn; ZQCL: ras/cas/we = 1/1/0, a[10]=1, ba=0; NOP: all csbar 0, ras/cas/we = 1/1/1, a=0, ba=0.
REQ-010 After the last rank's ZQ_WAIT, DONE: ready=1, busy=0, cke=1, NOP held.
REQ-011 ready SHALL rise exactly T_RESET+T_CKE+T_XPR+RANKS*(3*T_MRD+T_MOD+T_ZQINIT)+1 cycles after the sampling edge of REQ-004.
REQ-012 Timer SHALL be wide enough for the largest T_* parameter; parameters below 1 are illegal, checked by elaboration assertion.

Reset
REQ-013 On reset high at any clk edge, including mid-sequence: state IDLE, ready=0, busy=0, resetbar=0, cke=0, csbar all 1, ras/cas/we=1, ba=0, a=0, odt=0, timer and rank counter 0, registered initddr 0.
REQ-014 If initddr is high when reset releases, a sequence SHALL start on the first post-reset edge.

Structure
REQ-015 Package ddr3_init_pkg SHALL hold the state enum, the command encodings (NOP, DESELECT, MRS, ZQCL), and the MR issue order {2,3,1,0}.
REQ-016 A sub-module ddr3_wait_timer (loadable down-counter with done flag, width parameter) SHALL provide all waits.

Verification
REQ-017 RANKS=2, T_RESET=8, T_CKE=10, T_XPR=5, T_MRD=4, T_MOD=12, T_ZQINIT=16; initddr high -> ready rises exactly 104 cycles later; resetbar low exactly 8 cycles.
REQ-018 Same parameters, MR0=14'h1520, MR1=14'h0044 -> rank0 MRS sequence ba=2,3,1,0 with a=MR2,MR3,MR1,MR0 spaced 4,4,4 cycles, ZQCL 12 cycles after MR0 with a[10]=1; rank1 repeats with csbar=2'b01.
REQ-019 Pulse reset at cycle 30 of a sequence -> next cycle all outputs at REQ-013 values; re-raise initddr -> full 104-cycle sequence.
REQ-020 Toggle initddr while busy -> no effect, ready still at cycle 104; toggle in DONE -> ready=0 next cycle, new sequence, ready again after 104.
REQ-021 RANKS=1, all T_*=1 -> ready after 1+1+1+(3+1+1)+1 = 9 cycles, every command one cycle apart.
